alu_mdu_unit: RTL and testbench

Parametrised execute-stage ALU with integrated decode and an iterative multiply/divide unit. It takes the main decoder's ALUOp, opcode bit 5 and funct fields. It decodes the full RV32I register/immediate ALU set plus the RV32M extension. Single-cycle ops complete in one clock; mul/div ops run iteratively behind a valid/ready handshake. It replaces the purely combinational ALU decode/ALU pair when the core moves to a multi-cycle execute stage.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_op_decode.sv | 61 ++++++
 rtl/alu_mdu_unit.sv | 189 ++++++++++++++++++
 tb/tb_alu_mdu_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU / multiply-divide unit.
//   alu_op_e  : decoded operation (RV32I ALU set, RV32M set, ILLEGAL)
//   ALUOP_*   : main-decoder ALUOp encodings
//   state_e   : iterative-unit FSM states
//   cond_neg  : conditional two's-complement negate (magnitude helper);
//               callers size-cast operands in and results out, so one
//               definition serves every XLEN up to MAG_W/2.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ILLEGAL
  } alu_op_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  localparam int MAG_W = 128;

  function automatic logic [MAG_W-1:0] cond_neg(input logic [MAG_W-1:0] v, input logic neg);
    return neg ? (~v + MAG_W'(1)) : v;
  endfunction

  function automatic logic is_mul_op(input alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decode.
//   ALUOp    : 00 add, 01 sub, 10/11 decode from funct fields
//   opb5     : opcode bit 5 (R-type when 1)
//   funct3   : instruction funct3
//   funct7b5 : funct7 bit 5 (sub / sra)
//   funct7b0 : funct7 bit 0 (M extension on R-type)
//   op       : decoded operation
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic [1:0] ALUOp,
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  output alu_op_e    op
);

  always_comb begin
    op = OP_ADD;
    unique case (ALUOp)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      default: begin
        // funct7 = 0100001 is not a defined R-type encoding
        if (opb5 && funct7b5 && funct7b0) begin
          op = OP_ILLEGAL;
        end else if (ALUOp == ALUOP_FUNCT && opb5 && funct7b0) begin
          if (ENABLE_M == 0) begin
            op = OP_ILLEGAL;
          end else begin
            unique case (funct3)
              3'b000:  op = OP_MUL;
              3'b001:  op = OP_MULH;
              3'b010:  op = OP_MULHSU;
              3'b011:  op = OP_MULHU;
              3'b100:  op = OP_DIV;
              3'b101:  op = OP_DIVU;
              3'b110:  op = OP_REM;
              default: op = OP_REMU;
            endcase
          end
        end else begin
          unique case (funct3)
            3'b000:  op = (opb5 && funct7b5) ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = funct7b5 ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_mdu_unit.sv
// Execute-stage ALU with integrated decode and iterative multiply/divide.
// Single-cycle ops respond the cycle after acceptance; MUL*/DIV*/REM*
// take XLEN iterations plus a sign-fix cycle (latency XLEN+2).
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake
//   ALUOp, opb5, funct3, funct7b5, funct7b0 : decode inputs
//   a, b                 : operands (shift amount = b[$clog2(XLEN)-1:0])
//   out_valid            : one-cycle completion pulse
//   result, illegal      : registered response, held until next completion
//   zero                 : result == 0
module alu_mdu_unit
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic            opb5,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam int PW  = 2 * XLEN;
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state;
  logic [CW-1:0]   cnt;
  alu_op_e         op_q;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] acc_hi, acc_lo, mcand;

  alu_op_e         dec_op;
  logic            accept, a_sgn, b_sgn, div_zero, div_ovf, fast_div;
  logic [XLEN-1:0] ma, mb, single_res;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quot, remd, fix_res;

  function automatic logic [XLEN-1:0] alu_simple(input alu_op_e op,
                                                 input logic [XLEN-1:0] x,
                                                 input logic [XLEN-1:0] y);
    logic signed [XLEN-1:0] xs, ys;
    logic [SHW-1:0]         sh;
    xs = x;
    ys = y;
    sh = y[SHW-1:0];
    unique case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_SLL:  return x << sh;
      OP_SLT:  return {{(XLEN-1){1'b0}}, xs < ys};
      OP_SLTU: return {{(XLEN-1){1'b0}}, x < y};
      OP_XOR:  return x ^ y;
      OP_SRL:  return x >> sh;
      OP_SRA:  return $unsigned(xs >>> sh);
      OP_OR:   return x | y;
      OP_AND:  return x & y;
      default: return '0;
    endcase
  endfunction

  alu_op_decode #(.ENABLE_M(ENABLE_M)) u_dec (
    .ALUOp    (ALUOp),
    .opb5     (opb5),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .funct7b0 (funct7b0),
    .op       (dec_op)
  );

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign zero     = (result == '0);

  // Request side: operand magnitudes, fast paths, single-cycle result
  always_comb begin
    a_sgn    = (dec_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a[XLEN-1];
    b_sgn    = (dec_op inside {OP_MULH, OP_DIV, OP_REM}) && b[XLEN-1];
    ma       = XLEN'(cond_neg(MAG_W'(a), a_sgn));
    mb       = XLEN'(cond_neg(MAG_W'(b), b_sgn));
    div_zero = (b == '0);
    div_ovf  = (dec_op inside {OP_DIV, OP_REM}) && (a == SMIN) && (b == '1);
    fast_div = is_div_op(dec_op) && (div_zero || div_ovf);
    single_res = '0;
    if (fast_div) begin
      if (dec_op inside {OP_DIV, OP_DIVU}) single_res = div_zero ? '1 : a;
      else                                 single_res = div_zero ? a : '0;
    end else if (dec_op != OP_ILLEGAL) begin
      single_res = alu_simple(dec_op, a, b);
    end
  end

  // Iteration step and sign fix-up
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand};
    prod_fix  = PW'(cond_neg(MAG_W'({acc_hi, acc_lo}), neg_q));
    quot      = XLEN'(cond_neg(MAG_W'(acc_lo), neg_q));
    remd      = XLEN'(cond_neg(MAG_W'(acc_hi), neg_r));
    unique case (op_q)
      OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[PW-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quot;
      default:                      fix_res = remd;
    endcase
  end

  // Control: FSM, counter, registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (is_mul_op(dec_op)) begin
              state <= S_MUL;
            end else if (is_div_op(dec_op) && !fast_div) begin
              state <= S_DIV;
            end else begin
              result    <= single_res;
              illegal   <= (dec_op == OP_ILLEGAL);
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
        default: begin
          result    <= fix_res;
          illegal   <= 1'b0;
          out_valid <= 1'b1;
          cnt       <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: shift-add multiply (hi:lo = product, lo starts as multiplier)
  // and restoring divide (hi = partial remainder, lo = dividend -> quotient)
  always_ff @(posedge clk) begin
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          op_q   <= dec_op;
          neg_q  <= a_sgn ^ b_sgn;
          neg_r  <= a_sgn;
          acc_hi <= '0;
          acc_lo <= is_mul_op(dec_op) ? mb : ma;
          mcand  <= is_mul_op(dec_op) ? ma : mb;
        end
      end
      S_MUL: begin
        acc_hi <= mul_sum[XLEN:1];
        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
      end
      S_DIV: begin
        acc_hi <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        acc_lo <= {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mdu_unit.sv
module tb_alu_mdu_unit;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, opb5, funct7b5, funct7b0;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic [31:0] a, b, result;
  logic        out_valid, zero, illegal;

  logic        in_valid_m0, in_ready_m0, out_valid_m0, zero_m0, illegal_m0;
  logic [1:0]  aluop_m0;
  logic        opb5_m0, f7b5_m0, f7b0_m0;
  logic [2:0]  f3_m0;
  logic [31:0] a_m0, b_m0, result_m0;

  always #5 clk = ~clk;

  alu_mdu_unit #(.XLEN(XLEN), .ENABLE_M(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .opb5(opb5), .funct3(funct3), .funct7b5(funct7b5),
    .funct7b0(funct7b0), .a(a), .b(b), .out_valid(out_valid),
    .result(result), .zero(zero), .illegal(illegal)
  );

  alu_mdu_unit #(.XLEN(XLEN), .ENABLE_M(0)) dut_m0 (
    .clk(clk), .reset(reset), .in_valid(in_valid_m0), .in_ready(in_ready_m0),
    .ALUOp(aluop_m0), .opb5(opb5_m0), .funct3(f3_m0), .funct7b5(f7b5_m0),
    .funct7b0(f7b0_m0), .a(a_m0), .b(b_m0), .out_valid(out_valid_m0),
    .result(result_m0), .zero(zero_m0), .illegal(illegal_m0)
  );

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          at_edge;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endfunction

  // Monitor: every out_valid pulse pops one expected response
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: actual result=0x%08h required no response", result);
      end else begin
        mon_e = sb_q.pop_front();
        check("result",  result,              mon_e.res);
        check("illegal", {31'b0, illegal},    {31'b0, mon_e.ill});
        check("zero",    {31'b0, zero},       {31'b0, (mon_e.res == 32'h0)});
        check("latency", edge_cnt,            mon_e.at_edge);
      end
    end
  end

  task automatic issue(input logic [1:0] op2, input logic ob5, input logic [2:0] f3,
                       input logic f7b5, input logic f7b0,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic eill,
                       input bit iter, input bit expect_resp);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {31'b0, in_ready}, 32'h1);
      return;
    end
    ALUOp = op2; opb5 = ob5; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0;
    a = av; b = bv; in_valid = 1'b1;
    if (expect_resp) sb_q.push_back('{er, eill, edge_cnt + 1 + (iter ? XLEN + 1 : 0)});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // R-type shorthand: ALUOp=10, opb5=1
  task automatic rop(input logic [2:0] f3, input logic f7b5, input logic f7b0,
                     input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] er, input bit iter);
    issue(2'b10, 1'b1, f3, f7b5, f7b0, av, bv, er, 1'b0, iter, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ready_low_ok;
    int waited;
    reset = 1'b1; in_valid = 1'b0; ALUOp = 2'b00; opb5 = 1'b0; funct3 = 3'b0;
    funct7b5 = 1'b0; funct7b0 = 1'b0; a = '0; b = '0;
    in_valid_m0 = 1'b0; aluop_m0 = 2'b00; opb5_m0 = 1'b0; f3_m0 = 3'b0;
    f7b5_m0 = 1'b0; f7b0_m0 = 1'b0; a_m0 = '0; b_m0 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready",  {31'b0, in_ready},  32'h1);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_result",    result,             32'h0);
    check("rst_illegal",   {31'b0, illegal},   32'h0);
    check("rst_zero",      {31'b0, zero},      32'h1);

    // Single-cycle ALU ops
    rop(3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);             // SUB
    rop(3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);     // SRA
    rop(3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);     // SRL
    issue(2'b00, 1'b0, 3'b111, 1'b0, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 0, 1); // ALUOp add
    issue(2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 32'd5, 32'd5, 32'd0, 1'b0, 0, 1); // ALUOp sub
    issue(2'b10, 1'b0, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 0, 1); // I-type add
    rop(3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);             // SLT
    rop(3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);             // SLTU
    rop(3'b001, 1'b0, 1'b0, 32'd1, 32'h3F, 32'h8000_0000, 1'b0);            // SLL
    rop(3'b100, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0);            // XOR
    rop(3'b110, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0);            // OR
    rop(3'b111, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0);            // AND
    issue(2'b10, 1'b1, 3'b000, 1'b1, 1'b1, 32'd5, 32'd7, 32'd0, 1'b1, 0, 1); // illegal funct7

    // MULH with in_ready profile
    rop(3'b001, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b1);
    ready_low_ok = 1'b1;
    for (int i = 0; i < XLEN + 1; i++) begin
      @(negedge clk);
      if (in_ready) ready_low_ok = 1'b0;
    end
    check("mul_in_ready_low", {31'b0, ready_low_ok}, 32'h1);
    @(negedge clk);
    check("mul_in_ready_back", {31'b0, in_ready}, 32'h1);

    rop(3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b1);     // MULHU
    rop(3'b000, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b1);     // MUL
    rop(3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); // MULHSU

    // Divide fast paths
    rop(3'b100, 1'b0, 1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0);             // DIV /0
    rop(3'b110, 1'b0, 1'b1, 32'd7, 32'd0, 32'd7, 1'b0);                     // REM /0
    rop(3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0); // DIV ovf
    rop(3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);     // REM ovf

    // Iterative divide
    rop(3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);     // DIV -7/2
    rop(3'b110, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);     // REM -7%2
    rop(3'b111, 1'b0, 1'b1, 32'd7, 32'd3, 32'd1, 1'b1);                     // REMU
    rop(3'b101, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 1'b1);    // DIVU

    // Back-to-back single-cycle ops
    issue(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0, 0, 1);
    issue(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, 0, 1);
    issue(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd3, 32'd3, 32'd6, 1'b0, 0, 1);

    // ENABLE_M=0 instance: MUL encoding is illegal, ADD still works
    @(negedge clk);
    aluop_m0 = 2'b10; opb5_m0 = 1'b1; f3_m0 = 3'b000; f7b5_m0 = 1'b0; f7b0_m0 = 1'b1;
    a_m0 = 32'd3; b_m0 = 32'd4; in_valid_m0 = 1'b1;
    @(posedge clk);
    #1 in_valid_m0 = 1'b0;
    check("m0_out_valid", {31'b0, out_valid_m0}, 32'h1);
    check("m0_result",    result_m0,             32'h0);
    check("m0_illegal",   {31'b0, illegal_m0},   32'h1);
    check("m0_in_ready",  {31'b0, in_ready_m0},  32'h1);
    @(negedge clk);
    aluop_m0 = 2'b00; f7b0_m0 = 1'b0; a_m0 = 32'd2; b_m0 = 32'd3; in_valid_m0 = 1'b1;
    @(posedge clk);
    #1 in_valid_m0 = 1'b0;
    check("m0_add_result",  result_m0,           32'd5);
    check("m0_add_illegal", {31'b0, illegal_m0}, 32'h0);

    // Reset aborts an in-flight DIV
    rop(3'b100, 1'b0, 1'b1, 32'd100, 32'd7, 32'd0, 1'b1);
    void'(sb_q.pop_back());
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'b0, in_ready}, 32'h1);
    repeat (40) @(negedge clk);
    rop(3'b100, 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b1);

    waited = 0;
    while (sb_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("pending_responses", sb_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
